line_raster_engine: RTL
=======================

Name: line_raster_engine

Overview:
- Parametrised Bresenham line rasteriser, all eight octants, endpoints inclusive.
- Takes two endpoints plus a colour, then streams one framebuffer write (linear address + colour) per pixel over a valid/ready handshake.
- Sits between the vertex/primitive setup logic and the framebuffer write port.
- Replaces the horizontal-only line stepper; adds backpressure, clipping and a done pulse.

Parameters:
COORD_W, 10, width of x/y coordinates (unsigned)
H_RES, 400, pixels with x >= H_RES are clipped
V_RES, 240, pixels with y >= V_RES are clipped
STRIDE, 399, framebuffer row pitch used in address = x + y*STRIDE
ADDR_W, 17, framebuffer address width
COLOR_W, 9, pixel colour width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a line; sampled only in IDLE
x0, y0  in  COORD_W each  start point
x1, y1  in  COORD_W each  end point
color  in  COLOR_W  line colour
busy  out  1  high in SETUP, DRAW and DONE
done  out  1  one-cycle pulse when the line completes
pix_valid  out  1  pix_* outputs hold a pixel to write
pix_ready  in  1  framebuffer accepts the pixel
pix_addr  out  ADDR_W  x + y*STRIDE, truncated to ADDR_W
pix_x, pix_y  out  COORD_W each  current pixel coordinates
pix_color  out  COLOR_W  latched colour

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done and pix_valid are 0; pix_addr, pix_x, pix_y and pix_color are 0. All internal registers clear.
- Reset asserted mid-line aborts the line immediately. No done pulse. After release the block is in IDLE.
- IDLE:
  - start=1 latches x0, y0, x1, y1 and color, then moves to SETUP.
  - start while busy is ignored; it is not queued.
- SETUP (exactly 1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy.
  - Signed arithmetic, COORD_W+2 bits; no overflow for any legal input.
  - Current point = (x0,y0). Go to DRAW.
- DRAW:
  - pix_valid = 1 when the current point is in range (x<H_RES and y<V_RES).
  - A pixel advances on pix_valid & pix_ready, or automatically after one cycle when the point is clipped (pix_valid=0).
  - While pix_valid=1 and pix_ready=0, all pix_* outputs and internal state stay stable.
  - Advance rule:
    - If current point == (x1,y1): go to DONE.
    - Else: e2 = 2*err.
    - If e2 >= dy: err += dy, x += sx.
    - If e2 <= dx: err += dx, y += sy.
    - Both updates may happen in the same cycle (diagonal step). err accumulates both terms.
  - Pixel count = max(dx,|dy|)+1, including clipped points.
  - pix_addr is combinational from the registered pix_x/pix_y, or registered alongside them; it must be valid in the same cycle as pix_valid.
- DONE (1 cycle): done=1, pix_valid=0, busy=1. Then IDLE.
  - start in this cycle is ignored.
  - start held high into IDLE is accepted on the next cycle (back-to-back lines; 3-cycle overhead per line: SETUP, DONE, IDLE).
- Degenerate line (x0=x1, y0=y1): exactly one pixel, then DONE.
- A fully clipped line emits no pixel but still traverses all points and pulses done.
- Throughput: 1 pixel/cycle with pix_ready held high.
- Start-to-first-pix_valid latency: 2 cycles.

Test Plan:
- Horizontal line: (10,5)->(14,5), color=0x0A5, ready=1 -> pix_addr 2005,2006,2007,2008,2009 on consecutive cycles; pix_color=0x0A5; done pulses 1 cycle after the last pixel; busy falls with the IDLE return.
- Reverse vertical line: (3,7)->(3,4) -> pixels (3,7),(3,6),(3,5),(3,4), addrs 2796,2397,1998,1599.
- Steep octant: (0,0)->(2,5) -> exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); mirrored (2,5)->(0,0) gives the reverse-path set of 6 pixels.
- Backpressure: during (10,5)->(14,5), hold pix_ready low for 3 cycles on the 3rd pixel -> pix_addr=2007 and pix_valid=1 stay stable; the sequence resumes with no pixel lost or duplicated; 5 handshakes total.
- Clip and degenerate:
  - (397,0)->(402,0) -> only x=397,398,399 are emitted; done pulses after 6 stepped points.
  - (50,50)->(50,50) -> one pixel, addr 20000.
- Control: start pulsed in SETUP and DRAW -> ignored; reset driven low at the 2nd pixel -> busy, pix_valid and done go to 0 asynchronously; the next start after release draws the new line correctly.

Source files
------------

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser covering all eight octants, with both endpoints drawn.
// It latches two endpoints and a colour on i_start. It then streams one framebuffer
// write per pixel over a valid/ready handshake. Points outside H_RES x V_RES still
// take one step but are not emitted.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-low reset
//   i_start             begin a line (sampled only in IDLE)
//   i_x0, i_y0          start point
//   i_x1, i_y1          end point
//   i_color             line colour
//   o_busy              high in SETUP, DRAW and DONE
//   o_done              one-cycle pulse when the line completes
//   o_pix_valid         pixel write pending
//   i_pix_ready         framebuffer accepts the pixel
//   o_pix_addr          x + y*STRIDE, truncated to ADDR_W
//   o_pix_x, o_pix_y    current pixel coordinates
//   o_pix_color         latched colour
module line_raster_engine #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned H_RES   = 400,
  parameter int unsigned V_RES   = 240,
  parameter int unsigned STRIDE  = 399,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned COLOR_W = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [COLOR_W-1:0] i_color,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [ADDR_W-1:0]  o_pix_addr,
  output logic [COORD_W-1:0] o_pix_x,
  output logic [COORD_W-1:0] o_pix_y,
  output logic [COLOR_W-1:0] o_pix_color
);

  localparam int unsigned ERR_W = COORD_W + 2;
  localparam int unsigned E2_W  = COORD_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t                    r_state;
  logic [COORD_W-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [COLOR_W-1:0]        r_color;
  logic [COORD_W-1:0]        r_x, r_y;
  logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
  logic                      r_sx_neg, r_sy_neg;
  logic                      r_busy, r_done, r_pix_valid;
  logic [ADDR_W-1:0]         r_addr;

  state_t                    w_state_nxt;
  logic [COORD_W-1:0]        w_x_nxt, w_y_nxt;
  logic signed [ERR_W-1:0]   w_dx_nxt, w_dy_nxt, w_err_nxt;
  logic                      w_sx_neg_nxt, w_sy_neg_nxt;
  logic                      w_latch;
  logic                      w_adv;
  logic                      w_at_end;
  logic [COORD_W-1:0]        w_dx_abs, w_dy_abs;
  logic signed [E2_W-1:0]    w_e2, w_dx_ext, w_dy_ext;
  logic                      w_valid_nxt;
  logic [ADDR_W-1:0]         w_addr_nxt;

  // Absolute deltas from the latched endpoints, used only in SETUP.
  assign w_dx_abs = (r_x0 < r_x1) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_dy_abs = (r_y0 < r_y1) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  // Doubled error plus sign-extended deltas for the step decisions.
  assign w_e2     = {r_err[ERR_W-1], r_err} <<< 1;
  assign w_dx_ext = {r_dx[ERR_W-1], r_dx};
  assign w_dy_ext = {r_dy[ERR_W-1], r_dy};

  assign w_at_end = (r_x == r_x1) && (r_y == r_y1);
  // A clipped point steps on its own; a visible one waits for the handshake.
  assign w_adv    = !r_pix_valid || i_pix_ready;
  assign w_latch  = (r_state == S_IDLE) && i_start;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_dx_nxt     = r_dx;
    w_dy_nxt     = r_dy;
    w_err_nxt    = r_err;
    w_sx_neg_nxt = r_sx_neg;
    w_sy_neg_nxt = r_sy_neg;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_dx_nxt     = $signed({2'b00, w_dx_abs});
        w_dy_nxt     = -$signed({2'b00, w_dy_abs});
        w_err_nxt    = $signed({2'b00, w_dx_abs}) - $signed({2'b00, w_dy_abs});
        w_sx_neg_nxt = !(r_x0 < r_x1);
        w_sy_neg_nxt = !(r_y0 < r_y1);
        w_x_nxt      = r_x0;
        w_y_nxt      = r_y0;
        w_state_nxt  = S_DRAW;
      end
      S_DRAW: begin
        if (w_adv) begin
          if (w_at_end) begin
            w_state_nxt = S_DONE;
          end else begin
            // Both tests use the pre-step e2, so a diagonal step is allowed.
            if (w_e2 >= w_dy_ext) begin
              w_err_nxt = w_err_nxt + r_dy;
              w_x_nxt   = r_sx_neg ? (r_x - COORD_W'(1)) : (r_x + COORD_W'(1));
            end
            if (w_e2 <= w_dx_ext) begin
              w_err_nxt = w_err_nxt + r_dx;
              w_y_nxt   = r_sy_neg ? (r_y - COORD_W'(1)) : (r_y + COORD_W'(1));
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output flags and address are precomputed from the next point, so they are
  // registered in the same edge as the point itself.
  assign w_valid_nxt = (w_state_nxt == S_DRAW) &&
                       (32'(w_x_nxt) < H_RES) && (32'(w_y_nxt) < V_RES);
  assign w_addr_nxt  = ADDR_W'(32'(w_x_nxt) + 32'(w_y_nxt) * STRIDE);

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_color     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_latch) begin
        r_x0    <= i_x0;
        r_y0    <= i_y0;
        r_x1    <= i_x1;
        r_y1    <= i_y1;
        r_color <= i_color;
      end
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_err       <= w_err_nxt;
      r_sx_neg    <= w_sx_neg_nxt;
      r_sy_neg    <= w_sy_neg_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_pix_valid <= w_valid_nxt;
      r_addr      <= w_addr_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_addr  = r_addr;
  assign o_pix_x     = r_x;
  assign o_pix_y     = r_y;
  assign o_pix_color = r_color;

endmodule
